// File: rtl/btn_cmd_scheduler.sv
// Button front end for the game datapath: synchronise, debounce, latch presses as
// sticky requests, and hand out at most one command per video frame.
module btn_cmd_scheduler #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btnR,
    input  logic       btnL,
    input  logic       btnM,
    input  logic       btnT,
    input  logic       frame_tick,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [1:0] cmd_code,
    output logic [3:0] pending,
    output logic       dropped
);

    typedef enum logic {
        IDLE,
        ISSUE
    } stateT;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    stateT            state;
    stateT            stateNext;
    logic [3:0]       rawBtn;
    logic [3:0]       syncA;
    logic [3:0]       syncB;
    logic [3:0]       level;
    logic [3:0]       levelD;
    logic [3:0]       press;
    logic [3:0]       clearMask;
    logic [CNT_W-1:0] debounceCnt [4];
    logic [1:0]       winner;
    logic             rrLast;
    logic             fire;
    logic             launch;

    // Bit order {T,M,R,L} matches both pending and the command encoding.
    assign rawBtn = {btnT, btnM, btnR, btnL};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncA <= '0;
            syncB <= '0;
        end else begin
            syncA <= rawBtn;
            syncB <= syncA;
        end
    end

    // A level is accepted only after an unbroken run of mismatching samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
            for (int i = 0; i < 4; i++) begin
                debounceCnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (syncB[i] != level[i]) begin
                    if (debounceCnt[i] == CNT_MAX) begin
                        level[i]       <= syncB[i];
                        debounceCnt[i] <= '0;
                    end else begin
                        debounceCnt[i] <= debounceCnt[i] + 1'b1;
                    end
                end else begin
                    debounceCnt[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            levelD <= '0;
        end else begin
            levelD <= level;
        end
    end

    assign press     = level & ~levelD;
    assign fire      = (state == ISSUE) && cmd_ready;
    assign launch    = (state == IDLE) && frame_tick && (pending != 4'b0000);
    assign clearMask = fire ? (4'b0001 << cmd_code) : 4'b0000;

    // A press landing on the cycle its own command completes re-arms the bit silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            dropped <= 1'b0;
        end else begin
            pending <= (pending & ~clearMask) | press;
            dropped <= |(press & pending & ~clearMask);
        end
    end

    always_comb begin
        winner = 2'd0;
        if (pending[2]) begin
            winner = 2'd2;
        end else if (pending[3]) begin
            winner = 2'd3;
        end else if (pending[1] && pending[0]) begin
            winner = rrLast ? 2'd0 : 2'd1;
        end else if (pending[1]) begin
            winner = 2'd1;
        end else begin
            winner = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_code <= 2'd0;
            rrLast   <= 1'b0;
        end else begin
            if (launch) begin
                cmd_code <= winner;
            end
            if (fire && !cmd_code[1]) begin
                rrLast <= cmd_code[0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (launch) stateNext = ISSUE;
            ISSUE:   if (cmd_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        cmd_valid = (state == ISSUE);
    end

endmodule
